sport_rx_mc: RTL and testbench

- Next-generation SPORT receive controller.
- Deserialises RD into words up to DW bits, in single-word or multichannel frames of up to NCH words.
- Extends each word per DTYPE and buffers words in a FIFO read by the DSP core.
- Single-clock design: the serial clock arrives as a DSPCLK-synchronous sample strobe. Replaces the dual-clock receive path and its DSPCLK resynchroniser.

---
 rtl/sport_pkg.sv | 40 ++++
 rtl/sport_rx_fifo.sv | 72 +++++++
 rtl/sport_rx_mc.sv | 179 +++++++++++++++++
 tb/tb_sport_rx_mc.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sport_pkg.sv
// sport_pkg: shared FSM encoding, DTYPE codes, width limits and word extension helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package sport_pkg;

    localparam int DW_MIN  = 4;
    localparam int DW_MAX  = 32;
    localparam int NCH_MAX = 256;

    // One-hot receive FSM encoding.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_SHIFT  = 3'b010,
        ST_WSTART = 3'b100
    } sport_state_e;

    // DTYPE codes; 2'b1x is raw (zero-filled here, expanded downstream).
    localparam logic [1:0] DT_ZERO = 2'b00;
    localparam logic [1:0] DT_SIGN = 2'b01;
    localparam logic [1:0] DT_RAW  = 2'b10;

    // Extend a received word of slen+1 bits to DW_MAX bits.
    // Bits above slen are forced to zero, or to a copy of bit slen for DT_SIGN.
    function automatic logic [DW_MAX-1:0] sport_extend(
        input logic [DW_MAX-1:0]         raw,
        input logic [$clog2(DW_MAX)-1:0] slen,
        input logic [1:0]                dtype
    );
        logic [DW_MAX-1:0] mask;
        logic [DW_MAX-1:0] res;
        // ~(...1110 << slen) keeps bits [slen:0]; slen=31 yields all ones.
        mask = ~({{(DW_MAX-1){1'b1}}, 1'b0} << slen);
        res  = raw & mask;
        if (dtype == DT_SIGN && raw[slen]) begin
            res = res | ~mask;
        end
        return res;
    endfunction

endpackage

// File: rtl/sport_rx_fifo.sv
// sport_rx_fifo: synchronous DEPTH x WIDTH receive FIFO with push/pop, full/empty.
// Latency: a push is visible at the head (empty deasserts) the cycle after it is written.
// Backpressure: push while full without pop is dropped; pop while empty is ignored.
// Ports: clk, rst (sync clear), push/din, pop, dout (0 when empty), full, empty.
module sport_rx_fifo #(
    parameter  int WIDTH = 21,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             wr_en;
    logic             rd_en;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

    // A pop while full frees the slot the simultaneous push needs.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    assign dout = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !rd_en) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (rd_en && !wr_en) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/sport_rx_mc.sv
// sport_rx_mc: single-clock SPORT receiver, single-word or multichannel frames, into a word FIFO.
// Latency: word pushed (ISR) the DSPCLK cycle after its last-bit strobe; RX_VLD one cycle later.
// Backpressure: none toward the serial side; a push into a full FIFO without a pop is dropped and sets OVF.
// Ports: DSPCLK/RST, SP_EN, SCLK_STB/RFS/RD serial inputs, SLEN/MWORD/DTYPE config,
//        RX_RD pop, RX/CH/RX_VLD head, ISR, OVF, FSERR.
// Build option: define SPORT_RX_CHMASK_EN to add CHMASK[NCH-1:0]; masked channels are not pushed.
module sport_rx_mc
    import sport_pkg::*;
#(
    parameter  int DW    = 16,
    parameter  int NCH   = 32,
    parameter  int DEPTH = 4,
    localparam int SW    = $clog2(DW),
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           DSPCLK,
    input  logic           RST,
    input  logic           SP_EN,
    input  logic           SCLK_STB,
    input  logic           RFS,
    input  logic           RD,
    input  logic [SW-1:0]  SLEN,
    input  logic [CW-1:0]  MWORD,
    input  logic [1:0]     DTYPE,
    input  logic           RX_RD,
`ifdef SPORT_RX_CHMASK_EN
    input  logic [NCH-1:0] CHMASK,
`endif
    output logic [DW-1:0]  RX,
    output logic [CW-1:0]  CH,
    output logic           RX_VLD,
    output logic           ISR,
    output logic           OVF,
    output logic           FSERR
);

    sport_state_e  state_q, state_d;
    logic [SW-1:0] bcnt_q, bcnt_d;
    logic [SW-1:0] slen_q, slen_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] ch_q, ch_d;
    logic [DW-1:0] sr_q, sr_d;
    logic          push_q, push_d;
    logic [DW-1:0] word_q, word_d;
    logic [CW-1:0] wch_q, wch_d;
    logic          ovf_q, ovf_d;
    logic          fserr_q, fserr_d;

    logic [SW-1:0]     slen_in;
    logic [DW_MAX-1:0] ext_w;
    logic              ch_en;
    logic              clr;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW+DW-1:0]  fifo_dout;

    assign clr = RST || !SP_EN;

    // Words shorter than 3 bits are not supported; short SLEN codes round up.
    assign slen_in = (SLEN < SW'(2)) ? SW'(2) : SLEN;

`ifdef SPORT_RX_CHMASK_EN
    assign ch_en = CHMASK[ch_q];
`else
    assign ch_en = 1'b1;
`endif

    // bcnt holds the number of bits still to come after the current one;
    // the SHIFT strobe that brings it to zero carries the word's last bit.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        slen_d  = slen_q;
        wcnt_d  = wcnt_q;
        ch_d    = ch_q;
        sr_d    = sr_q;
        push_d  = 1'b0;
        word_d  = word_q;
        wch_d   = wch_q;
        fserr_d = fserr_q;
        ext_w   = '0;
        if (SCLK_STB) begin
            case (state_q)
                ST_IDLE: begin
                    if (RFS) begin
                        state_d = ST_SHIFT;
                        bcnt_d  = slen_in;
                        slen_d  = slen_in;
                        wcnt_d  = MWORD;
                        ch_d    = '0;
                        sr_d    = {{(DW-1){1'b0}}, RD};
                    end
                end
                ST_SHIFT: begin
                    // A frame sync inside a frame is flagged but otherwise ignored.
                    if (RFS) begin
                        fserr_d = 1'b1;
                    end
                    sr_d   = {sr_q[DW-2:0], RD};
                    bcnt_d = bcnt_q - SW'(1);
                    if (bcnt_q == SW'(1)) begin
                        ext_w   = sport_extend(DW_MAX'(sr_d), ($clog2(DW_MAX))'(slen_q), DTYPE);
                        word_d  = ext_w[DW-1:0];
                        wch_d   = ch_q;
                        push_d  = ch_en;
                        state_d = (wcnt_q == '0) ? ST_IDLE : ST_WSTART;
                    end
                end
                ST_WSTART: begin
                    if (RFS) begin
                        fserr_d = 1'b1;
                    end
                    sr_d    = {{(DW-1){1'b0}}, RD};
                    bcnt_d  = slen_in;
                    slen_d  = slen_in;
                    wcnt_d  = wcnt_q - CW'(1);
                    ch_d    = ch_q + CW'(1);
                    state_d = ST_SHIFT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // A push is lost only when the FIFO is full and no pop frees a slot.
    assign ovf_d = ovf_q || (push_q && fifo_full && !RX_RD);

    always_ff @(posedge DSPCLK) begin
        if (clr) begin
            state_q <= ST_IDLE;
            bcnt_q  <= '0;
            slen_q  <= '0;
            wcnt_q  <= '0;
            ch_q    <= '0;
            sr_q    <= '0;
            push_q  <= 1'b0;
            word_q  <= '0;
            wch_q   <= '0;
            ovf_q   <= 1'b0;
            fserr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            slen_q  <= slen_d;
            wcnt_q  <= wcnt_d;
            ch_q    <= ch_d;
            sr_q    <= sr_d;
            push_q  <= push_d;
            word_q  <= word_d;
            wch_q   <= wch_d;
            ovf_q   <= ovf_d;
            fserr_q <= fserr_d;
        end
    end

    sport_rx_fifo #(
        .WIDTH (CW + DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (DSPCLK),
        .rst   (clr),
        .push  (push_q),
        .din   ({wch_q, word_q}),
        .pop   (RX_RD),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {CH, RX} = fifo_dout;
    assign RX_VLD   = !fifo_empty;
    // ISR marks every completed word presented to the FIFO; a drop is reported by OVF.
    assign ISR      = push_q;
    assign OVF      = ovf_q;
    assign FSERR    = fserr_q;

endmodule

// File: tb/tb_sport_rx_mc.sv
module tb_sport_rx_mc;

    logic        DSPCLK = 1'b0;
    logic        RST    = 1'b1;
    logic        SP_EN  = 1'b1;
    logic        SCLK_STB = 1'b0;
    logic        RFS    = 1'b0;
    logic        RD     = 1'b0;
    logic [3:0]  SLEN   = 4'd7;
    logic [4:0]  MWORD  = 5'd0;
    logic [1:0]  DTYPE  = 2'b00;
    logic        RX_RD  = 1'b0;
`ifdef SPORT_RX_CHMASK_EN
    logic [31:0] CHMASK = 32'hFFFF_FFFF;
`endif
    logic [15:0] RX;
    logic [4:0]  CH;
    logic        RX_VLD;
    logic        ISR;
    logic        OVF;
    logic        FSERR;

    int n_chk  = 0;
    int n_fail = 0;
    int isr_cnt = 0;
    int isr_base;
    logic isr_at_push;
    logic vld_at_push;

    sport_rx_mc #(.DW(16), .NCH(32), .DEPTH(4)) dut (
        .DSPCLK   (DSPCLK),
        .RST      (RST),
        .SP_EN    (SP_EN),
        .SCLK_STB (SCLK_STB),
        .RFS      (RFS),
        .RD       (RD),
        .SLEN     (SLEN),
        .MWORD    (MWORD),
        .DTYPE    (DTYPE),
        .RX_RD    (RX_RD),
`ifdef SPORT_RX_CHMASK_EN
        .CHMASK   (CHMASK),
`endif
        .RX       (RX),
        .CH       (CH),
        .RX_VLD   (RX_VLD),
        .ISR      (ISR),
        .OVF      (OVF),
        .FSERR    (FSERR)
    );

    always #5 DSPCLK = ~DSPCLK;

    always @(posedge DSPCLK) begin
        if (ISR) isr_cnt = isr_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge. The gap cycle after the
    // strobe edge is the push cycle for a word's last bit.
    task automatic strobe(input logic b, input logic fs, input logic pop_in_gap);
        SCLK_STB = 1'b1;
        RD       = b;
        RFS      = fs;
        @(posedge DSPCLK); #1;
        SCLK_STB = 1'b0;
        RFS      = 1'b0;
        RX_RD    = pop_in_gap;
        isr_at_push = ISR;
        vld_at_push = RX_VLD;
        @(posedge DSPCLK); #1;
        RX_RD    = 1'b0;
    endtask

    // Sends len bits of w MSB-first; fs_mask selects the bit positions carrying RFS.
    task automatic send_word(input logic [31:0] w, input int len, input logic [31:0] fs_mask,
                             input logic pop_last);
        for (int i = len - 1; i >= 0; i--) begin
            strobe(w[i], fs_mask[i], pop_last && (i == 0));
        end
    endtask

    task automatic pop();
        RX_RD = 1'b1;
        @(posedge DSPCLK); #1;
        RX_RD = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge DSPCLK);
        #1;
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_rx", 32'(RX), 32'h0);
        check("rst_ch", 32'(CH), 32'h0);
        check("rst_vld", 32'(RX_VLD), 32'h0);
        check("rst_isr", 32'(ISR), 32'h0);
        check("rst_ovf", 32'(OVF), 32'h0);
        check("rst_fserr", 32'(FSERR), 32'h0);
        RST = 1'b0;
        idle(2);

        // 8-bit sign-extended word, ISR in the push cycle, RX_VLD one later
        SLEN = 4'd7; DTYPE = 2'b01; MWORD = 5'd0;
        isr_base = isr_cnt;
        send_word(32'h81, 8, 32'h80, 1'b0);
        check("sx_isr_push", 32'(isr_at_push), 32'h1);
        check("sx_vld_push", 32'(vld_at_push), 32'h0);
        check("sx_isr_after", 32'(ISR), 32'h0);
        check("sx_isr_cnt", 32'(isr_cnt - isr_base), 32'h1);
        check("sx_vld", 32'(RX_VLD), 32'h1);
        check("sx_rx", 32'(RX), 32'hFF81);
        check("sx_ch", 32'(CH), 32'h0);
        pop();
        check("sx_empty", 32'(RX_VLD), 32'h0);

        // Zero extension
        DTYPE = 2'b00;
        send_word(32'h81, 8, 32'h80, 1'b0);
        check("zx_rx", 32'(RX), 32'h0081);
        pop();

        // SLEN=1 clamps to 3-bit words
        SLEN = 4'd1;
        send_word(32'h5, 3, 32'h4, 1'b0);
        check("clamp_rx", 32'(RX), 32'h0005);
        check("clamp_vld", 32'(RX_VLD), 32'h1);
        pop();

        // Three-channel frame of 16-bit words
        SLEN = 4'd15; MWORD = 5'd2;
        isr_base = isr_cnt;
        send_word(32'h1234, 16, 32'h8000, 1'b0);
        send_word(32'hABCD, 16, 32'h0, 1'b0);
        send_word(32'h0001, 16, 32'h0, 1'b0);
        idle(2);
        check("mc_isr_cnt", 32'(isr_cnt - isr_base), 32'h3);
        check("mc_state", 32'(dut.state_q), 32'h1);
        check("mc_rx0", 32'(RX), 32'h1234);
        check("mc_ch0", 32'(CH), 32'h0);
        pop();
        check("mc_rx1", 32'(RX), 32'hABCD);
        check("mc_ch1", 32'(CH), 32'h1);
        pop();
        check("mc_rx2", 32'(RX), 32'h0001);
        check("mc_ch2", 32'(CH), 32'h2);
        pop();
        check("mc_empty", 32'(RX_VLD), 32'h0);
        check("mc_fserr", 32'(FSERR), 32'h0);

        // Overflow: five words into a four-deep FIFO with no pops
        SLEN = 4'd7; MWORD = 5'd0;
        for (int k = 1; k <= 5; k++) send_word(32'(k), 8, 32'h80, 1'b0);
        check("ovf_set", 32'(OVF), 32'h1);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("ovf_rx%0d", k), 32'(RX), 32'(k));
            pop();
        end
        check("ovf_drop", 32'(RX_VLD), 32'h0);
        check("ovf_sticky", 32'(OVF), 32'h1);
        SP_EN = 1'b0;
        idle(1);
        check("ovf_clr", 32'(OVF), 32'h0);
        SP_EN = 1'b1;
        idle(1);

        // Full FIFO: push and pop in the same cycle does not overflow
        for (int k = 1; k <= 4; k++) send_word(32'h10 + 32'(k), 8, 32'h80, 1'b0);
        check("full_ovf0", 32'(OVF), 32'h0);
        send_word(32'h15, 8, 32'h80, 1'b1);
        check("pp_ovf", 32'(OVF), 32'h0);
        for (int k = 2; k <= 5; k++) begin
            check($sformatf("pp_rx%0d", k), 32'(RX), 32'h10 + 32'(k));
            pop();
        end
        check("pp_empty", 32'(RX_VLD), 32'h0);

        // Frame sync mid-word: flagged, word still intact
        send_word(32'hA5, 8, 32'h88, 1'b0);
        check("fs_err", 32'(FSERR), 32'h1);
        check("fs_rx", 32'(RX), 32'h00A5);
        check("fs_state", 32'(dut.state_q), 32'h1);

        // SP_EN low mid-word: everything back to reset values, no push
        isr_base = isr_cnt;
        for (int k = 0; k < 4; k++) strobe(1'b1, k == 0, 1'b0);
        SP_EN = 1'b0;
        idle(1);
        check("dis_rx", 32'(RX), 32'h0);
        check("dis_ch", 32'(CH), 32'h0);
        check("dis_vld", 32'(RX_VLD), 32'h0);
        check("dis_isr", 32'(ISR), 32'h0);
        check("dis_ovf", 32'(OVF), 32'h0);
        check("dis_fserr", 32'(FSERR), 32'h0);
        SP_EN = 1'b1;
        idle(4);
        check("dis_isr_cnt", 32'(isr_cnt - isr_base), 32'h0);
        check("dis_state", 32'(dut.state_q), 32'h1);
        send_word(32'h3C, 8, 32'h80, 1'b0);
        check("dis_next_rx", 32'(RX), 32'h003C);
        pop();

`ifdef SPORT_RX_CHMASK_EN
        // Channel mask: only channels 0 and 2 reach the FIFO
        CHMASK = 32'h5; MWORD = 5'd2;
        isr_base = isr_cnt;
        send_word(32'h0A, 8, 32'h80, 1'b0);
        send_word(32'h0B, 8, 32'h0, 1'b0);
        send_word(32'h0C, 8, 32'h0, 1'b0);
        idle(2);
        check("mask_isr_cnt", 32'(isr_cnt - isr_base), 32'h2);
        check("mask_rx0", 32'(RX), 32'h0A);
        check("mask_ch0", 32'(CH), 32'h0);
        pop();
        check("mask_rx2", 32'(RX), 32'h0C);
        check("mask_ch2", 32'(CH), 32'h2);
        pop();
        check("mask_empty", 32'(RX_VLD), 32'h0);
        CHMASK = 32'hFFFF_FFFF; MWORD = 5'd0;
`endif

        // RST overrides an enabled port with a word pending
        send_word(32'h55, 8, 32'h80, 1'b0);
        RST = 1'b1;
        idle(1);
        check("rst2_vld", 32'(RX_VLD), 32'h0);
        check("rst2_rx", 32'(RX), 32'h0);
        RST = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
